boot_loader: RTL and testbench
==============================

Name: boot_loader

Overview:
- Memory-bus initiator that loads program images into the word-addressed RAM from a byte stream, replacing file preload in synthesised builds.
- Drives the same 17-bit word address, 4-lane byte write enable and 32-bit write-data interface the CPU drives.
- Holds the CPU inactive until a GO frame arrives, then releases the bus permanently until reset.
- Sits beside the CPU; an external mux selects loader or CPU bus using cpu_hold.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT, 1024, max clocks between bytes inside a frame before abort; 0 disables.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low (0 = reset).
- rx_data  in  [0:7]  stream byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  loader accepts byte when rx_valid & rx_ready at posedge.
- mem_address  out  [15:31]  word address.
- mem_write_en  out  [0:3]  byte-lane write enables; lane 0 = bits [0:7].
- mem_data_out  out  [0:31]  write data.
- cpu_hold  out  1  1 = CPU held inactive, loader owns bus.
- load_err  out  1  sticky error flag.
- err_code  out  [0:1]  01 checksum, 10 bad command, 11 timeout; last error wins.
- words_loaded  out  [0:15]  words written since reset, saturating at 16'hFFFF.

Behaviour:
- Reset values: rx_ready 0, mem_address 0, mem_write_en 0, mem_data_out 0, cpu_hold 1, load_err 0, err_code 0, words_loaded 0, state HUNT.
- All outputs are registered. rx_ready = (state not WRITE, not RUN).
- Frame format, big-endian:
  - SYNC, then CMD.
  - CMD 8'h01 = LOAD: ADDR (3 bytes; low 17 bits used, top 7 ignored), COUNT (2 bytes, words), COUNT×4 data bytes, CHK.
  - CMD 8'h02 = GO: no payload.
- States:
  - HUNT: bytes other than SYNC_BYTE are discarded silently; SYNC_BYTE -> CMD.
  - CMD: 01 -> ADDR; 02 -> RUN; other -> HUNT, err 10.
  - ADDR: 3 bytes shift into the address register -> COUNT.
  - COUNT: 2 bytes. Result 0 -> CSUM. Nonzero -> DATA.
  - DATA: bytes fill lanes 0,1,2,3 in order. After the 4th byte -> WRITE.
  - WRITE: exactly one cycle.
    - mem_write_en = 4'hF, mem_data_out = assembled word, mem_address = current address.
    - On exit: address +1 (wraps 17'h1FFFF -> 0), remaining count -1, words_loaded +1.
    - Next state: DATA if remaining > 0, else CSUM.
  - CSUM: accept 1 byte. If (8-bit sum of all data bytes + CHK) mod 256 != 0, set load_err with err 01. Either way -> HUNT.
  - RUN: cpu_hold = 0 from the cycle after GO is accepted. rx_ready 0, mem_write_en 0. Only reset exits RUN.
- mem_write_en is 0 in every state except WRITE. Writes are thus written by RAM at the posedge ending the WRITE cycle.
- Throughput: 4 accepted bytes + 1 bubble per word. Peak 5 clocks/word.
- Timeout: an idle counter clears on each accepted byte and counts while in CMD/ADDR/COUNT/DATA/CSUM. Reaching TIMEOUT -> HUNT with err 11. Words already written remain in memory.
- Checksum and byte-index counters clear on entry to CMD.
- A SYNC_BYTE value seen mid-frame is data, not resync.
- Reset asserted mid-frame or mid-WRITE: immediate return to reset values. A partial word is never written.
- rx_valid without rx_ready: byte is not consumed; the source must hold it.

Decomposition:
- Shared package: state encoding, SYNC_BYTE default, CMD_LOAD/CMD_GO codes, err_code constants.
- One sub-module, boot_word_asm:
  - byte-lane shift/assemble register, 2-bit lane index, running 8-bit checksum;
  - inputs: byte, strobe, clear;
  - outputs: word, word_full, sum.
  - The FSM, address/count registers and timeout live in boot_loader.

Test Plan:
- LOAD addr 0x00010, count 2, data 12345678 9ABCDEF0, valid CHK -> mem_write_en=F twice, at addr 0x10 then 0x11, with those words. load_err 0, words_loaded 2, RAM readback matches.
- Same frame with CHK off by 1 -> both words still written; load_err 1, err_code 01; next valid frame accepted normally.
- Garbage 00 FF 5A, then SYNC, CMD 07 -> no writes, err_code 10, returns to HUNT; following GO frame drops cpu_hold.
- LOAD addr 0x1FFFF, count 2 -> writes at 0x1FFFF then 0x00000.
- TIMEOUT=16; frame stalls after 2 data bytes for 20 clocks -> err_code 11, no write, HUNT. Also reset=0 pulse mid-DATA -> all outputs at reset values, cpu_hold 1.
- GO frame, then further LOAD bytes on rx -> rx_ready stays 0, mem_write_en stays 0, cpu_hold stays 0.

Source files
------------

// File: rtl/boot_loader_pkg.sv
// Shared definitions for the byte-stream boot loader: FSM encoding,
// frame command codes and error codes.
package boot_loader_pkg;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_CMD,
    ST_ADDR,
    ST_COUNT,
    ST_DATA,
    ST_WRITE,
    ST_CSUM,
    ST_RUN
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  localparam logic [7:0] CMD_LOAD = 8'h01;
  localparam logic [7:0] CMD_GO   = 8'h02;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_CHECKSUM = 2'b01;
  localparam logic [1:0] ERR_BAD_CMD  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

endpackage

// File: rtl/boot_word_asm.sv
// Assembles four stream bytes into one big-endian memory word (lane 0 first)
// and keeps a running 8-bit sum of every byte strobed in since the last clear.
module boot_word_asm (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  data_byte,
  input  logic        strobe,
  input  logic        clear,
  output logic [31:0] word,
  output logic        word_full,
  output logic [7:0]  sum
);

  logic [1:0]  lane_reg;
  logic [7:0]  sum_reg;
  logic [31:0] word_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lane_reg <= 2'd0;
      sum_reg  <= 8'd0;
    end else if (clear) begin
      lane_reg <= 2'd0;
      sum_reg  <= 8'd0;
    end else if (strobe) begin
      lane_reg <= lane_reg + 2'd1;
      sum_reg  <= sum_reg + data_byte;
    end
  end

  // Lane gi occupies bits [31-8*gi -: 8], so the first byte lands in the MSBs.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        word_reg[31-8*gi -: 8] <= 8'd0;
      end else if (strobe && !clear && lane_reg == 2'(gi)) begin
        word_reg[31-8*gi -: 8] <= data_byte;
      end
    end
  end

  // High on the strobe that fills lane 3; the word is complete on the next cycle.
  assign word_full = strobe && !clear && (lane_reg == 2'd3);
  assign word      = word_reg;
  assign sum       = sum_reg;

endmodule

// File: rtl/boot_loader.sv
// Byte-stream program loader: parses SYNC/CMD frames, writes words into the
// CPU's RAM interface, then hands the bus to the CPU after a GO frame.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [0:7]   rx_data,
  input  logic         rx_valid,
  output logic         rx_ready,
  output logic [15:31] mem_address,
  output logic [0:3]   mem_write_en,
  output logic [0:31]  mem_data_out,
  output logic         cpu_hold,
  output logic         load_err,
  output logic [0:1]   err_code,
  output logic [0:15]  words_loaded
);

  localparam int IDLE_W = $clog2(TIMEOUT + 2);

  state_t state_reg, state_next;

  logic [7:0]        rx_byte;
  logic              accept;
  logic              counting;
  logic              timeout_hit;
  logic [IDLE_W-1:0] idle_reg;
  logic [1:0]        byte_idx_reg;
  logic [16:0]       addr_reg;
  logic [15:0]       count_reg;
  logic [15:0]       count_shift;
  logic [15:0]       words_reg;
  logic              rx_ready_reg;
  logic [3:0]        mem_we_reg;
  logic              cpu_hold_reg;
  logic              load_err_reg;
  logic [1:0]        err_code_reg;
  logic              err_set;
  logic [1:0]        err_val;
  logic [7:0]        csum_total;
  logic              asm_strobe;
  logic              asm_clear;
  logic [31:0]       asm_word;
  logic              asm_full;
  logic [7:0]        asm_sum;

  assign rx_byte     = rx_data;
  assign accept      = rx_valid && rx_ready_reg;
  assign counting    = state_reg inside {ST_CMD, ST_ADDR, ST_COUNT, ST_DATA, ST_CSUM};
  assign timeout_hit = (TIMEOUT != 0) && counting && !accept &&
                       (idle_reg == IDLE_W'(TIMEOUT));
  assign count_shift = {count_reg[7:0], rx_byte};
  assign csum_total  = asm_sum + rx_byte;
  assign asm_strobe  = accept && (state_reg == ST_DATA);
  assign asm_clear   = (state_reg == ST_HUNT) && (state_next == ST_CMD);

  boot_word_asm u_word_asm (
    .clock     (clock),
    .reset     (reset),
    .data_byte (rx_byte),
    .strobe    (asm_strobe),
    .clear     (asm_clear),
    .word      (asm_word),
    .word_full (asm_full),
    .sum       (asm_sum)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_reg <= ST_HUNT;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    err_set    = 1'b0;
    err_val    = ERR_NONE;
    if (timeout_hit) begin
      state_next = ST_HUNT;
      err_set    = 1'b1;
      err_val    = ERR_TIMEOUT;
    end else begin
      case (state_reg)
        ST_HUNT:  if (accept && rx_byte == SYNC_BYTE) state_next = ST_CMD;
        ST_CMD: begin
          if (accept) begin
            if (rx_byte == CMD_LOAD)    state_next = ST_ADDR;
            else if (rx_byte == CMD_GO) state_next = ST_RUN;
            else begin
              state_next = ST_HUNT;
              err_set    = 1'b1;
              err_val    = ERR_BAD_CMD;
            end
          end
        end
        ST_ADDR:  if (accept && byte_idx_reg == 2'd2) state_next = ST_COUNT;
        ST_COUNT: begin
          if (accept && byte_idx_reg == 2'd1)
            state_next = (count_shift == 16'd0) ? ST_CSUM : ST_DATA;
        end
        ST_DATA:  if (asm_full) state_next = ST_WRITE;
        ST_WRITE: state_next = (count_reg != 16'd1) ? ST_DATA : ST_CSUM;
        ST_CSUM: begin
          if (accept) begin
            state_next = ST_HUNT;
            if (csum_total != 8'd0) begin
              err_set = 1'b1;
              err_val = ERR_CHECKSUM;
            end
          end
        end
        ST_RUN:   state_next = ST_RUN;
        default:  state_next = ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_ready_reg <= 1'b0;
      mem_we_reg   <= 4'h0;
      cpu_hold_reg <= 1'b1;
      load_err_reg <= 1'b0;
      err_code_reg <= ERR_NONE;
      idle_reg     <= '0;
      byte_idx_reg <= 2'd0;
      addr_reg     <= 17'd0;
      count_reg    <= 16'd0;
      words_reg    <= 16'd0;
    end else begin
      // Outputs are decoded from the next state so they line up with it.
      rx_ready_reg <= (state_next != ST_WRITE) && (state_next != ST_RUN);
      mem_we_reg   <= (state_next == ST_WRITE) ? 4'hF : 4'h0;
      cpu_hold_reg <= (state_next != ST_RUN);
      if (err_set) begin
        load_err_reg <= 1'b1;
        err_code_reg <= err_val;
      end
      if (!counting || accept)               idle_reg <= '0;
      else if (idle_reg != IDLE_W'(TIMEOUT)) idle_reg <= idle_reg + 1'b1;
      if (state_next != state_reg) byte_idx_reg <= 2'd0;
      else if (accept)             byte_idx_reg <= byte_idx_reg + 2'd1;
      if (accept && state_reg == ST_ADDR) addr_reg <= {addr_reg[8:0], rx_byte};
      else if (state_reg == ST_WRITE)     addr_reg <= addr_reg + 17'd1;
      if (accept && state_reg == ST_COUNT) count_reg <= count_shift;
      else if (state_reg == ST_WRITE)      count_reg <= count_reg - 16'd1;
      if (state_reg == ST_WRITE && words_reg != 16'hFFFF) words_reg <= words_reg + 16'd1;
    end
  end

  assign rx_ready     = rx_ready_reg;
  assign mem_address  = addr_reg;
  assign mem_write_en = mem_we_reg;
  assign mem_data_out = asm_word;
  assign cpu_hold     = cpu_hold_reg;
  assign load_err     = load_err_reg;
  assign err_code     = err_code_reg;
  assign words_loaded = words_reg;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: table of LOAD frames with expected writes,
// then hand-written timeout, reset-mid-frame and GO/bad-command sequences.
module tb_boot_loader;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [0:7]   rx_data = 8'h00;
  logic         rx_valid = 1'b0;
  logic         rx_ready;
  logic [15:31] mem_address;
  logic [0:3]   mem_write_en;
  logic [0:31]  mem_data_out;
  logic         cpu_hold;
  logic         load_err;
  logic [0:1]   err_code;
  logic [0:15]  words_loaded;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  boot_loader #(.TIMEOUT(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .mem_address  (mem_address),
    .mem_write_en (mem_write_en),
    .mem_data_out (mem_data_out),
    .cpu_hold     (cpu_hold),
    .load_err     (load_err),
    .err_code     (err_code),
    .words_loaded (words_loaded)
  );

  typedef struct {
    logic [16:0] addr;
    logic [31:0] data;
    logic [3:0]  en;
  } wr_t;

  wr_t wr_q[$];

  always @(negedge clock)
    if (mem_write_en != 4'h0) wr_q.push_back('{mem_address, mem_data_out, mem_write_en});

  typedef struct {
    string        name;
    int           nb;
    logic [127:0] bytes;
    int           nw;
    logic [16:0]  a0, a1;
    logic [31:0]  d0, d1;
    logic         err;
    logic [1:0]   code;
    logic [15:0]  words;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && n < 64) begin
      @(negedge clock);
      n++;
    end
    if (n >= 64) begin
      tests++;
      fails++;
      $display("FAIL send_byte: rx_ready=%b after 64 cycles, expected 1", rx_ready);
    end
    @(negedge clock);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " rx_ready"},     32'(rx_ready), 32'd0);
    check({tag, " mem_address"},  32'(mem_address), 32'd0);
    check({tag, " mem_write_en"}, 32'(mem_write_en), 32'd0);
    check({tag, " mem_data_out"}, 32'(mem_data_out), 32'd0);
    check({tag, " cpu_hold"},     32'(cpu_hold), 32'd1);
    check({tag, " load_err"},     32'(load_err), 32'd0);
    check({tag, " err_code"},     32'(err_code), 32'd0);
    check({tag, " words_loaded"}, 32'(words_loaded), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] seq[$];
    logic bad_ready, bad_we, bad_hold;

    // Data sum 0x438 -> CHK 0xC8 makes the byte total 0 mod 256.
    vecs[0] = '{"load_ok", 16, 128'hA5_01_000010_0002_12345678_9ABCDEF0_C8,
                2, 17'h00010, 17'h00011, 32'h12345678, 32'h9ABCDEF0, 1'b0, 2'b00, 16'd2};
    vecs[1] = '{"load_badchk", 16, 128'hA5_01_000010_0002_12345678_9ABCDEF0_C9,
                2, 17'h00010, 17'h00011, 32'h12345678, 32'h9ABCDEF0, 1'b1, 2'b01, 16'd4};
    vecs[2] = '{"load_syncdata", 12, {96'hA5_01_000020_0001_A5A5A5A5_6C, 32'h0},
                1, 17'h00020, 17'h00000, 32'hA5A5A5A5, 32'h0, 1'b1, 2'b01, 16'd5};
    vecs[3] = '{"load_wrap", 16, 128'hA5_01_FFFFFF_0002_00000001_00000002_FD,
                2, 17'h1FFFF, 17'h00000, 32'h00000001, 32'h00000002, 1'b1, 2'b01, 16'd7};
    vecs[4] = '{"load_zero", 8, {64'hA5_01_000100_0000_00, 64'h0},
                0, 17'h0, 17'h0, 32'h0, 32'h0, 1'b1, 2'b01, 16'd7};

    repeat (3) @(negedge clock);
    check_reset_values("por");
    reset = 1'b1;
    @(negedge clock);

    for (int v = 0; v < 5; v++) begin
      wr_q.delete();
      for (int i = 0; i < vecs[v].nb; i++) send_byte(vecs[v].bytes[127-8*i -: 8]);
      rx_valid = 1'b0;
      repeat (3) @(negedge clock);
      check({vecs[v].name, " nwrites"}, 32'(wr_q.size()), 32'(vecs[v].nw));
      for (int k = 0; k < vecs[v].nw && k < wr_q.size(); k++) begin
        check({vecs[v].name, " addr"}, 32'(wr_q[k].addr), 32'(k == 0 ? vecs[v].a0 : vecs[v].a1));
        check({vecs[v].name, " data"}, wr_q[k].data, k == 0 ? vecs[v].d0 : vecs[v].d1);
        check({vecs[v].name, " we"},   32'(wr_q[k].en), 32'hF);
      end
      check({vecs[v].name, " load_err"}, 32'(load_err), 32'(vecs[v].err));
      check({vecs[v].name, " err_code"}, 32'(err_code), 32'(vecs[v].code));
      check({vecs[v].name, " words"},    32'(words_loaded), 32'(vecs[v].words));
      check({vecs[v].name, " cpu_hold"}, 32'(cpu_hold), 32'd1);
      $display("[TB] frame %s: %0d writes, load_err=%b err_code=%b words=%0d",
               vecs[v].name, wr_q.size(), load_err, err_code, words_loaded);
    end

    // Stall after two data bytes; TIMEOUT=16 fires between 10 and 20 idle clocks.
    wr_q.delete();
    seq = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'h01, 8'h11, 8'h22};
    foreach (seq[i]) send_byte(seq[i]);
    rx_valid = 1'b0;
    repeat (10) @(negedge clock);
    check("timeout early err_code", 32'(err_code), 32'h1);
    repeat (10) @(negedge clock);
    check("timeout err_code", 32'(err_code), 32'h3);
    check("timeout load_err", 32'(load_err), 32'd1);
    seq = '{8'h33, 8'h44, 8'h56};
    foreach (seq[i]) send_byte(seq[i]);
    rx_valid = 1'b0;
    repeat (3) @(negedge clock);
    check("timeout nwrites", 32'(wr_q.size()), 32'd0);
    check("timeout words", 32'(words_loaded), 32'd7);
    $display("[TB] frame timeout: %0d writes, err_code=%b", wr_q.size(), err_code);

    // Reset pulse with three of four data bytes in.
    wr_q.delete();
    seq = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h50, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33};
    foreach (seq[i]) send_byte(seq[i]);
    rx_data = 8'h44;
    reset = 1'b0;
    #1;
    check_reset_values("mid_data");
    repeat (2) @(negedge clock);
    reset = 1'b1;
    send_byte(8'h44);
    rx_valid = 1'b0;
    repeat (3) @(negedge clock);
    check("reset partial nwrites", 32'(wr_q.size()), 32'd0);
    check("reset words", 32'(words_loaded), 32'd0);
    $display("[TB] frame reset_mid_data: %0d writes", wr_q.size());

    // Garbage, bad command, then GO.
    wr_q.delete();
    seq = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h07};
    foreach (seq[i]) send_byte(seq[i]);
    rx_valid = 1'b0;
    repeat (3) @(negedge clock);
    check("badcmd err_code", 32'(err_code), 32'h2);
    check("badcmd load_err", 32'(load_err), 32'd1);
    check("badcmd nwrites", 32'(wr_q.size()), 32'd0);
    check("badcmd cpu_hold", 32'(cpu_hold), 32'd1);
    check("badcmd rx_ready", 32'(rx_ready), 32'd1);
    $display("[TB] frame bad_cmd: err_code=%b", err_code);

    send_byte(8'hA5);
    send_byte(8'h02);
    check("go cpu_hold", 32'(cpu_hold), 32'd0);
    check("go rx_ready", 32'(rx_ready), 32'd0);
    $display("[TB] frame go: cpu_hold=%b", cpu_hold);

    bad_ready = 1'b0;
    bad_we    = 1'b0;
    bad_hold  = 1'b0;
    seq = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h10, 8'h00, 8'h01, 8'h12, 8'h34, 8'h56};
    foreach (seq[i]) begin
      rx_data  = seq[i];
      rx_valid = 1'b1;
      @(negedge clock);
      if (rx_ready !== 1'b0)       bad_ready = 1'b1;
      if (mem_write_en !== 4'h0)   bad_we    = 1'b1;
      if (cpu_hold !== 1'b0)       bad_hold  = 1'b1;
    end
    rx_valid = 1'b0;
    check("run rx_ready held 0", 32'(bad_ready), 32'd0);
    check("run we held 0", 32'(bad_we), 32'd0);
    check("run cpu_hold held 0", 32'(bad_hold), 32'd0);
    check("run nwrites", 32'(wr_q.size()), 32'd0);
    $display("[TB] frame post_go_bytes: %0d writes", wr_q.size());

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
